// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default cycle constants for the PLL lock reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_RESET_HOLD_CYCLES   = 16;
  localparam int DEF_GLITCH_CYCLES       = 4;
  localparam int DEF_LOSS_COUNT_WIDTH    = 8;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1 << 20;

endpackage

// File: rtl/pll_lock_reset_sequencer_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Qualifies PLL lock, stretches the core reset and re-sequences on lock loss.
// Optional lock timeout with sticky FAULT state: define PLL_SEQ_TIMEOUT_EN.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int GLITCH_CYCLES      = DEF_GLITCH_CYCLES,
  parameter int LOSS_COUNT_WIDTH   = DEF_LOSS_COUNT_WIDTH
`ifdef PLL_SEQ_TIMEOUT_EN
  , parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pll_lock,
  output logic                        rst_out,
  output logic                        ready,
  output logic [LOSS_COUNT_WIDTH-1:0] loss_count,
  output logic [2:0]                  state_dbg
`ifdef PLL_SEQ_TIMEOUT_EN
  , output logic                      timeout
`endif
);

  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int GLITCH_W = $clog2(GLITCH_CYCLES + 1);

  logic lock_s;

  seq_state_e                  state_q, state_d;
  logic [STABLE_W-1:0]         stable_q, stable_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [GLITCH_W-1:0]         glitch_q, glitch_d;
  logic [LOSS_COUNT_WIDTH-1:0] loss_d;

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    stable_d = stable_q;
    hold_d   = hold_q;
    glitch_d = glitch_q;
    loss_d   = loss_count;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d  = ST_STABILIZE;
          stable_d = STABLE_W'(1);
        end
      end
      ST_STABILIZE: begin
        // A lock drop outranks the terminal count.
        if (!lock_s) begin
          state_d  = ST_WAIT_LOCK;
          stable_d = '0;
        end else if (stable_q == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d  = ST_HOLD;
          stable_d = '0;
          hold_d   = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
          state_d  = ST_RUN;
          hold_d   = '0;
          glitch_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (lock_s) begin
          glitch_d = '0;
        end else if (glitch_q == GLITCH_W'(GLITCH_CYCLES - 1)) begin
          state_d  = ST_WAIT_LOCK;
          glitch_d = '0;
          if (loss_count != '1) loss_d = loss_count + 1'b1;
        end else begin
          glitch_d = glitch_q + 1'b1;
        end
      end
`ifdef PLL_SEQ_TIMEOUT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_WAIT_LOCK;
    endcase
`ifdef PLL_SEQ_TIMEOUT_EN
    // The timeout keeps running across STABILIZE restarts; only reaching RUN clears it.
    to_cnt_d = to_cnt_q;
    if (state_q == ST_WAIT_LOCK || state_q == ST_STABILIZE) begin
      if (to_cnt_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
        state_d  = ST_FAULT;
        stable_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    if (state_d == ST_RUN) to_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_LOCK;
      stable_q   <= '0;
      hold_q     <= '0;
      glitch_q   <= '0;
      loss_count <= '0;
      rst_out    <= 1'b1;
      ready      <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      to_cnt_q   <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      hold_q     <= hold_d;
      glitch_q   <= glitch_d;
      loss_count <= loss_d;
      // Outputs follow the next state so they switch on the transition edge itself.
      rst_out    <= (state_d != ST_RUN);
      ready      <= (state_d == ST_RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      timeout    <= (state_d == ST_FAULT);
`endif
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for pll_lock_reset_sequencer: cycle-exact vector table plus loss/reset/timeout sequences.
module tb_pll_lock_reset_sequencer;

  localparam int LCW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pll_lock = 1'b0;
  logic           rst_out;
  logic           ready;
  logic [LCW-1:0] loss_count;
  logic [2:0]     state_dbg;
`ifdef PLL_SEQ_TIMEOUT_EN
  logic           timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_reset_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (4),
    .GLITCH_CYCLES      (3),
    .LOSS_COUNT_WIDTH   (LCW)
`ifdef PLL_SEQ_TIMEOUT_EN
    , .LOCK_TIMEOUT_CYCLES (32)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .rst_out    (rst_out),
    .ready      (ready),
    .loss_count (loss_count),
    .state_dbg  (state_dbg)
`ifdef PLL_SEQ_TIMEOUT_EN
    , .timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  rst;
    logic  lock;
    int    n;      // cycles this row is applied; outputs checked after every one
    logic  ro;
    logic  rdy;
    int    st;
    int    loss;
    string tag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string tag, input logic r, input logic l, input int n,
                     input logic ro, input logic rdy, input int st, input int loss);
    vec_t v;
    v.tag = tag; v.rst = r; v.lock = l; v.n = n;
    v.ro = ro; v.rdy = rdy; v.st = st; v.loss = loss;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input logic val, input int budget, input string name);
    int k = 0;
    while (ready !== val && k < budget) begin
      step();
      k++;
    end
    check(name, ready, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Clean lock: pll_lock rises before edge 1, ready on edge 14.
    add("clean",     1, 0, 1, 1, 0, 0, 0);
    add("clean",     0, 1, 2, 1, 0, 0, 0);
    add("clean",     0, 1, 7, 1, 0, 1, 0);
    add("clean",     0, 1, 4, 1, 0, 2, 0);
    add("clean",     0, 1, 3, 0, 1, 3, 0);
    // Two-cycle dip in RUN is filtered.
    add("glitch2",   0, 0, 2, 0, 1, 3, 0);
    add("glitch2",   0, 1, 4, 0, 1, 3, 0);
    // Three-cycle dip: lost on the third synced-low edge, then full re-sequence.
    add("glitch3",   0, 0, 3, 0, 1, 3, 0);
    add("glitch3",   0, 1, 1, 0, 1, 3, 0);
    add("glitch3",   0, 1, 1, 1, 0, 0, 1);
    add("relock",    0, 1, 7, 1, 0, 1, 1);
    add("relock",    0, 1, 4, 1, 0, 2, 1);
    add("relock",    0, 1, 2, 0, 1, 3, 1);
    // Unstable lock: high 5, low 2, high; reset also clears loss_count.
    add("unstable",  1, 0, 1, 1, 0, 0, 0);
    add("unstable",  0, 1, 2, 1, 0, 0, 0);
    add("unstable",  0, 1, 3, 1, 0, 1, 0);
    add("unstable",  0, 0, 2, 1, 0, 1, 0);
    add("unstable",  0, 1, 2, 1, 0, 0, 0);
    add("unstable",  0, 1, 7, 1, 0, 1, 0);
    add("unstable",  0, 1, 4, 1, 0, 2, 0);
    add("unstable",  0, 1, 2, 0, 1, 3, 0);
    // Drop coinciding with the STABILIZE terminal count: back to WAIT_LOCK.
    add("stab_drop", 1, 0, 1, 1, 0, 0, 0);
    add("stab_drop", 0, 1, 2, 1, 0, 0, 0);
    add("stab_drop", 0, 1, 5, 1, 0, 1, 0);
    add("stab_drop", 0, 0, 2, 1, 0, 1, 0);
    add("stab_drop", 0, 0, 2, 1, 0, 0, 0);
    // Drop coinciding with the HOLD terminal count: back to WAIT_LOCK.
    add("hold_drop", 1, 0, 1, 1, 0, 0, 0);
    add("hold_drop", 0, 1, 2, 1, 0, 0, 0);
    add("hold_drop", 0, 1, 7, 1, 0, 1, 0);
    add("hold_drop", 0, 1, 2, 1, 0, 2, 0);
    add("hold_drop", 0, 0, 2, 1, 0, 2, 0);
    add("hold_drop", 0, 0, 2, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        rst      = vecs[i].rst;
        pll_lock = vecs[i].lock;
        step();
        check($sformatf("%s[%0d.%0d].rst_out", vecs[i].tag, i, c), rst_out, vecs[i].ro);
        check($sformatf("%s[%0d.%0d].ready", vecs[i].tag, i, c), ready, vecs[i].rdy);
        check($sformatf("%s[%0d.%0d].state", vecs[i].tag, i, c), state_dbg, vecs[i].st);
        check($sformatf("%s[%0d.%0d].loss", vecs[i].tag, i, c), loss_count, vecs[i].loss);
      end
    end

    // Saturation: five losses on a 2-bit counter end at 3.
    rst = 1'b0;
    pll_lock = 1'b1;
    wait_ready(1'b1, 40, "sat_relock0");
    check("sat_loss0", loss_count, 0);
    for (int i = 1; i <= 5; i++) begin
      pll_lock = 1'b0;
      wait_ready(1'b0, 10, $sformatf("sat_drop%0d", i));
      check($sformatf("sat_rst_out%0d", i), rst_out, 1);
      check($sformatf("sat_loss%0d", i), loss_count, (i > 3) ? 3 : i);
      pll_lock = 1'b1;
      wait_ready(1'b1, 40, $sformatf("sat_relock%0d", i));
      check($sformatf("sat_run_rst_out%0d", i), rst_out, 0);
    end

    // Reset in the middle of HOLD aborts the sequence and clears loss_count.
    begin
      int k = 0;
      pll_lock = 1'b0;
      wait_ready(1'b0, 10, "mid_hold_drop");
      pll_lock = 1'b1;
      while (state_dbg !== 3'd2 && k < 40) begin
        step();
        k++;
      end
      check("mid_hold_reached", state_dbg, 2);
      check("mid_hold_rst_out", rst_out, 1);
      step();
      rst = 1'b1;
      step();
      check("mid_hold_rst.state", state_dbg, 0);
      check("mid_hold_rst.rst_out", rst_out, 1);
      check("mid_hold_rst.ready", ready, 0);
      check("mid_hold_rst.loss", loss_count, 0);
      rst = 1'b0;
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    // No lock for 32 cycles: sticky FAULT until rst.
    rst = 1'b1;
    pll_lock = 1'b0;
    step();
    check("to_reset.timeout", timeout, 0);
    rst = 1'b0;
    repeat (31) step();
    check("to_31.state", state_dbg, 0);
    check("to_31.timeout", timeout, 0);
    step();
    check("to_32.state", state_dbg, 4);
    check("to_32.timeout", timeout, 1);
    check("to_32.rst_out", rst_out, 1);
    check("to_32.ready", ready, 0);
    pll_lock = 1'b1;
    repeat (20) step();
    check("to_sticky.state", state_dbg, 4);
    check("to_sticky.timeout", timeout, 1);
    rst = 1'b1;
    step();
    check("to_clear.state", state_dbg, 0);
    check("to_clear.timeout", timeout, 0);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
